// File: rtl/cpu_memory_pkg.sv
// Shared constants and loader state encoding for the unified CPU memory.
package cpu_memory_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4096;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2
  } ld_state_e;

endpackage

// File: rtl/mem_array_4k16.sv
// Single write port / single registered read port word array.
// Read-before-write on the same address; the array itself is never reset,
// only the read register is.
module mem_array_4k16 #(
  parameter int ADDR_W = cpu_memory_pkg::ADDR_W,
  parameter int DATA_W = cpu_memory_pkg::DATA_W,
  parameter int DEPTH  = cpu_memory_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port: commit on the edge the enable is sampled high.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port: samples the old word on a same-address write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cpu_memory.sv
// Unified CPU memory with a byte-serial program loader. While the loader is
// active the CPU may still read, but its stores are dropped.
module cpu_memory #(
  parameter int ADDR_W = cpu_memory_pkg::ADDR_W,
  parameter int DATA_W = cpu_memory_pkg::DATA_W,
  parameter int DEPTH  = cpu_memory_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] Din,
  input  logic              MemLoad,
  output logic [DATA_W-1:0] Dout,
  input  logic              LdStart,
  input  logic [ADDR_W-1:0] LdBase,
  input  logic [7:0]        LdByte,
  input  logic              LdValid,
  input  logic              LdStop,
  output logic              Busy,
  output logic [ADDR_W-1:0] LdAddr,
  output logic              LdDone,
  output logic              LdErr
);

  import cpu_memory_pkg::*;

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q,   ptr_d;
  logic [7:0]        hi_q,    hi_d;
  logic              err_q,   err_d;
  logic              done_q,  done_d;
  logic              ld_we;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Loader next-state: restart beats stop, stop beats a data byte.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hi_d    = hi_q;
    err_d   = err_q;
    done_d  = 1'b0;
    ld_we   = 1'b0;
    if (LdStart) begin
      state_d = ST_HI;
      ptr_d   = LdBase;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_HI: begin
          if (LdStop) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (LdValid) begin
            hi_d    = LdByte;
            state_d = ST_LO;
          end
        end
        ST_LO: begin
          if (LdStop) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (LdValid) begin
            ld_we   = 1'b1;
            ptr_d   = ptr_q + 1'b1;
            state_d = ST_HI;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Loader state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      hi_q    <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign Busy   = (state_q != ST_IDLE);
  assign LdAddr = ptr_q;
  assign LdDone = done_q;
  assign LdErr  = err_q;

  // Write-port mux: the loader owns the port while busy, otherwise the CPU.
  always_comb begin
    mem_we    = MemLoad;
    mem_waddr = Addr;
    mem_wdata = Din;
    if (Busy) begin
      mem_we    = ld_we;
      mem_waddr = ptr_q;
      mem_wdata = {hi_q, LdByte};
    end
  end

  mem_array_4k16 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (Addr),
    .rdata (Dout)
  );

endmodule

// File: doc/cpu_memory.md
# cpu_memory

Unified 4096×16 word memory that answers the CPU's memory interface: it returns read data for the requested address and commits stores when the CPU's memory-load strobe is raised. It also holds a byte-serial program loader, so a host can fill memory before or between CPU runs. The CPU continues to read while the loader is active, but the memory blocks CPU stores for that time.

## Interface
Parameters:
- ADDR_W, 12, word address width (matches CPU Addr)
- DATA_W, 16, word width (matches CPU Din/Dout)
- DEPTH, 4096, number of words (2**ADDR_W)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- Addr  in  12  CPU word address
- Din  in  16  CPU store data (driven by the CPU's Dout)
- MemLoad  in  1  CPU store strobe; 1 = write Din to mem[Addr] at this edge
- Dout  out  16  read data to CPU (CPU's Din)
- LdStart  in  1  begin or restart a load at LdBase
- LdBase  in  12  first word address of the load
- LdByte  in  8  loader data byte, high byte first
- LdValid  in  1  LdByte valid this cycle
- LdStop  in  1  end the load
- Busy  out  1  loader active; CPU stores are ignored
- LdAddr  out  12  next word address the loader will write
- LdDone  out  1  one-cycle pulse when a load ends
- LdErr  out  1  sticky flag: the load ended with a dangling high byte

## Operation
- CPU read: at every edge, Dout <= mem[Addr]. Reads are serviced in all states, including while Busy.
- CPU write: if MemLoad and !Busy at the edge, mem[Addr] <= Din. If Busy, the store is dropped silently.
- Read/write collision at the same address is read-before-write: Dout gets the old word, and the new word is visible one cycle later.
- Loader FSM states:
  - IDLE: Busy=0. LdStart → HI, ptr <= LdBase, LdErr <= 0.
  - HI: Busy=1, waiting for the high byte.
    - LdStop → IDLE with LdDone pulse.
    - Otherwise LdValid → hi <= LdByte, go to LO.
  - LO: Busy=1, waiting for the low byte.
    - LdStop → IDLE with LdDone pulse and LdErr <= 1; the partial word is discarded.
    - Otherwise LdValid → mem[ptr] <= {hi, LdByte}, ptr <= ptr+1, go to HI.
- Loader priority, highest first: rst > LdStart > LdStop > LdValid.
  - LdStart in HI or LO restarts: ptr reloads, any partial byte is dropped, LdErr clears, no LdDone.
  - LdValid in the same cycle as LdStop: the byte is dropped.
- Pointer is modulo 4096: a write at 4095 is followed by ptr = 0, and the load continues.
- LdAddr = ptr, always.
- Loader writes and CPU writes never occur in the same cycle, because CPU stores are gated by Busy.
- Reset:
  - Outputs: Dout=0, Busy=0, LdDone=0, LdErr=0, LdAddr=0.
  - FSM goes to IDLE and the hi register clears.
  - Memory array contents are not cleared.
  - Reset during a load abandons it with no LdDone pulse.

## Timing
- Read latency: 1 cycle. Addr is sampled at edge N, and Dout is valid after edge N.
- Write: committed at the edge where MemLoad is sampled high.
- Busy is registered. It rises on the edge after LdStart is sampled, so a CPU store in the same cycle as the accepting LdStart still commits.
- Busy falls on the same edge at which LdDone rises.
- The loader accepts one byte per cycle, so maximum fill rate is one word per 2 cycles. A word's write commits at the edge where its low byte is sampled.
- LdDone is high for exactly one cycle. LdErr holds until the next LdStart or rst.

## Structure
- Shared package holds:
  - the FSM state encoding (IDLE/HI/LO, 2 bits);
  - the width constants ADDR_W, DATA_W, DEPTH.
- Sub-module `mem_array_4k16`: 1 write port and 1 registered read port, read-before-write, no reset on the array.
- The top level contains:
  - the loader FSM;
  - the write-port mux: loader when Busy, else CPU gated by MemLoad.

## Test plan
- CPU store then load: MemLoad=1, Addr=0x010, Din=0xBEEF. Next cycle Addr=0x010, MemLoad=0 → Dout=0xBEEF one cycle later.
- Collision: mem[0x020]=0x1111. Store 0x2222 to 0x020 while reading 0x020 → Dout=0x1111 that cycle, then 0x2222 the next.
- Load: LdStart with LdBase=0x100, then bytes 0x12,0x34,0x56,0x78, then LdStop.
  - Required: mem[0x100]=0x1234, mem[0x101]=0x5678, LdAddr=0x102, LdDone pulses once, LdErr=0.
  - A CPU store attempted while Busy leaves its target unchanged.
- Wrap: LdBase=0xFFF, bytes 0xAA,0xBB,0xCC,0xDD → mem[0xFFF]=0xAABB, mem[0x000]=0xCCDD, LdAddr=0x001.
- Abort: LdStart, byte 0x99, then LdStop in LO.
  - Required: no word written, LdErr=1, LdDone pulse.
  - A subsequent LdStart clears LdErr.
- Reset mid-load: rst after one high byte → Busy=0, LdAddr=0, Dout=0, no LdDone, earlier-written words retained.
